// File: rtl/eth_tx_fcs_append_pkg.sv
// rtl/eth_tx_fcs_append_pkg.sv - CRC-32 constants, FSM encoding and FCS byte select for the TX FCS stage
package eth_tx_fcs_append_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PAD     = 2'd2,
    ST_FCS     = 2'd3
  } state_t;

  // FCS goes out complemented, least significant byte first
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    case (idx)
      2'd0:    return fcs[7:0];
      2'd1:    return fcs[15:8];
      2'd2:    return fcs[23:16];
      default: return fcs[31:24];
    endcase
  endfunction

endpackage

// File: rtl/eth_tx_fcs_append_lfsr.sv
// rtl/eth_tx_fcs_append_lfsr.sv - combinational Galois LFSR/CRC next-state over one data word
module lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;

  // Reflected mode shifts right and consumes data LSB first (Ethernet bit order)
  always_comb begin
    s  = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = s >> 1;
        if (fb) s = s ^ POLY_REV;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = s << 1;
        if (fb) s = s ^ LFSR_POLY;
      end
    end
    state_out = s;
  end

endmodule

// File: rtl/eth_tx_fcs_append.sv
// rtl/eth_tx_fcs_append.sv - Ethernet TX framing: pad short frames and append the 4-byte FCS
module eth_tx_fcs_append
  import eth_tx_fcs_append_pkg::*;
#(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy
);

  localparam logic [15:0] PAD_LIMIT = 16'(MIN_FRAME_LENGTH - 4);

  state_t      state, state_next;
  logic [15:0] count, count_next, count_inc;
  logic [31:0] crc, crc_next, crc_step;
  logic [7:0]  crc_din;
  logic [1:0]  fcs_idx, fcs_idx_next;
  logic        tuser_hold, tuser_hold_next;
  logic [7:0]  tdata_next;
  logic        tvalid_next, tlast_next, tuser_next;
  logic        load_allowed, pad_short;

  assign load_allowed  = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = load_allowed && !rst && (state == ST_IDLE || state == ST_PAYLOAD);
  assign busy          = (state != ST_IDLE) || m_axis_tvalid;

  assign crc_din   = (state == ST_PAD) ? 8'h00 : s_axis_tdata;
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
  // Compared against the count including the byte being accepted now
  assign pad_short = (ENABLE_PADDING != 0) && (count_inc < PAD_LIMIT);

  lfsr #(
    .LFSR_WIDTH(32),
    .LFSR_POLY (CRC32_POLY),
    .REVERSE   (1'b1),
    .DATA_WIDTH(8)
  ) u_crc (
    .data_in  (crc_din),
    .state_in (crc),
    .state_out(crc_step)
  );

  always_comb begin
    state_next      = state;
    count_next      = count;
    crc_next        = crc;
    fcs_idx_next    = fcs_idx;
    tuser_hold_next = tuser_hold;
    tdata_next      = m_axis_tdata;
    tvalid_next     = m_axis_tvalid;
    tlast_next      = m_axis_tlast;
    tuser_next      = m_axis_tuser;
    if (load_allowed) begin
      case (state)
        ST_IDLE, ST_PAYLOAD: begin
          if (s_axis_tvalid) begin
            tdata_next  = s_axis_tdata;
            tvalid_next = 1'b1;
            tlast_next  = 1'b0;
            tuser_next  = 1'b0;
            crc_next    = crc_step;
            count_next  = count_inc;
            if (s_axis_tlast) begin
              tuser_hold_next = s_axis_tuser;
              state_next      = pad_short ? ST_PAD : ST_FCS;
            end else begin
              state_next = ST_PAYLOAD;
            end
          end else begin
            tvalid_next = 1'b0;
          end
        end
        ST_PAD: begin
          tdata_next  = 8'h00;
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
          tuser_next  = 1'b0;
          crc_next    = crc_step;
          count_next  = count_inc;
          if (count_inc >= PAD_LIMIT) state_next = ST_FCS;
        end
        ST_FCS: begin
          tdata_next   = fcs_byte(crc, fcs_idx);
          tvalid_next  = 1'b1;
          tlast_next   = (fcs_idx == 2'd3);
          tuser_next   = tuser_hold && (fcs_idx == 2'd3);
          fcs_idx_next = fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state_next = ST_IDLE;
            crc_next   = CRC32_INIT;
            count_next = 16'd0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= 16'd0;
      crc           <= CRC32_INIT;
      fcs_idx       <= 2'd0;
      tuser_hold    <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      crc           <= crc_next;
      fcs_idx       <= fcs_idx_next;
      tuser_hold    <= tuser_hold_next;
      m_axis_tdata  <= tdata_next;
      m_axis_tvalid <= tvalid_next;
      m_axis_tlast  <= tlast_next;
      m_axis_tuser  <= tuser_next;
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_append.sv
// tb/tb_eth_tx_fcs_append.sv - randomized self-checking bench for eth_tx_fcs_append against a frame-level model
module tb_eth_tx_fcs_append;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic [1:0] s_tvalid;
  logic       s_tlast, s_tuser, m_tready;
  wire  [1:0] s_tready, m_tvalid, m_tlast, m_tuser, busy;
  wire  [7:0] m_tdata0, m_tdata1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit rand_ready = 1'b0;
  bit mon_sel    = 1'b0;

  bq_t out_data, exp_data;
  bit  out_last[$], out_user[$], exp_last[$], exp_user[$];
  int  out_cyc[$];

  // Instance 0: padding disabled; instance 1: padding to 64 bytes
  eth_tx_fcs_append #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(64)) dut_np (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]), .busy(busy[0]));

  eth_tx_fcs_append #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(64)) dut_pad (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]), .busy(busy[1]));

  wire [7:0] mon_tdata  = mon_sel ? m_tdata1 : m_tdata0;
  wire       mon_tvalid = mon_sel ? m_tvalid[1] : m_tvalid[0];
  wire       mon_tlast  = mon_sel ? m_tlast[1] : m_tlast[0];
  wire       mon_tuser  = mon_sel ? m_tuser[1] : m_tuser[0];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic       stall_prev = 1'b0;
  logic [7:0] d_prev;
  logic       l_prev, u_prev;

  // Output monitor: records transfers and checks hold-under-stall
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (mon_tvalid !== 1'b1 || mon_tdata !== d_prev || mon_tlast !== l_prev || mon_tuser !== u_prev) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b u=%b, required v=1 d=%h l=%b u=%b",
                   mon_tvalid, mon_tdata, mon_tlast, mon_tuser, d_prev, l_prev, u_prev);
        end
      end
      if (mon_tvalid && m_tready) begin
        out_data.push_back(mon_tdata);
        out_last.push_back(mon_tlast);
        out_user.push_back(mon_tuser);
        out_cyc.push_back(cycle);
      end
      stall_prev = mon_tvalid && !m_tready;
      d_prev = mon_tdata;
      l_prev = mon_tlast;
      u_prev = mon_tuser;
    end
  end

  function automatic logic [31:0] crc_raw(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t rand_frame(input int len);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
    return f;
  endfunction

  task automatic add_expected(input bit pad, input bq_t data, input bit user);
    bq_t f = data;
    logic [31:0] c;
    while (pad && f.size() < 60) f.push_back(8'h00);
    c = ~crc_raw(f);
    foreach (f[i]) begin
      exp_data.push_back(f[i]);
      exp_last.push_back(1'b0);
      exp_user.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_data.push_back(c[8*k +: 8]);
      exp_last.push_back(k == 3);
      exp_user.push_back(k == 3 && user);
    end
  endtask

  task automatic clear_queues();
    out_data.delete(); out_last.delete(); out_user.delete(); out_cyc.delete();
    exp_data.delete(); exp_last.delete(); exp_user.delete();
  endtask

  function automatic int first_diff();
    int n = (out_data.size() < exp_data.size()) ? out_data.size() : exp_data.size();
    for (int i = 0; i < n; i++)
      if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i] || out_user[i] !== exp_user[i])
        return i;
    if (out_data.size() != exp_data.size()) return n;
    return -1;
  endfunction

  task automatic drive_frame(input bit sel, input bq_t data, input bit user, input int gap_pct);
    int t;
    bit hs;
    for (int i = 0; i < data.size(); i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        s_tvalid = 2'b00;
        @(posedge clk); #1;
      end
      s_tvalid      = 2'b00;
      s_tvalid[sel] = 1'b1;
      s_tdata       = data[i];
      s_tlast       = (i == data.size() - 1);
      s_tuser       = s_tlast ? user : 1'b0;
      t  = 0;
      hs = 1'b0;
      while (!hs && t < 5000) begin
        @(negedge clk);
        hs = s_tready[sel];
        @(posedge clk); #1;
        t++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL accept_timeout: byte %0d not accepted, required acceptance within 5000 cycles", i);
      end
    end
    s_tvalid = 2'b00;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (out_data.size() < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tuser} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 000000", {m_tvalid, m_tlast, m_tuser});
    end
    checks++;
    if ({m_tdata1, m_tdata0} !== 16'h0) begin
      errors++; $display("FAIL reset_tdata: got %h, required 0000", {m_tdata1, m_tdata0});
    end
    checks++;
    if (s_tready !== 2'b00) begin
      errors++; $display("FAIL reset_tready: got %b, required 00", s_tready);
    end
    checks++;
    if (busy !== 2'b00) begin
      errors++; $display("FAIL reset_busy: got %b, required 00", busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 2'b11) begin
      errors++; $display("FAIL idle_tready: got %b, required 11", s_tready);
    end
  endtask

  task automatic test_known_vector();
    bq_t f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int d;
    mon_sel = 1'b0;
    clear_queues();
    add_expected(1'b0, f, 1'b0);
    drive_frame(1'b0, f, 1'b0, 0);
    wait_beats(13);
    checks++;
    if (out_data.size() != 13) begin
      errors++; $display("FAIL nopad_beats: got %0d, required 13", out_data.size());
    end
    checks++;
    if ({out_data[9], out_data[10], out_data[11], out_data[12]} !== 32'h2639F4CB) begin
      errors++;
      $display("FAIL nopad_fcs_tail: got %h %h %h %h, required 26 39 f4 cb",
               out_data[9], out_data[10], out_data[11], out_data[12]);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL nopad_stream: beat %0d got %h/%b/%b, required %h/%b/%b",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d]);
    end
  endtask

  task automatic test_min_pad();
    bq_t f = '{8'hAA};
    int d, zeros;
    mon_sel = 1'b1;
    clear_queues();
    add_expected(1'b1, f, 1'b0);
    drive_frame(1'b1, f, 1'b0, 0);
    wait_beats(64);
    checks++;
    if (out_data.size() != 64) begin
      errors++; $display("FAIL pad_beats: got %0d, required 64", out_data.size());
    end
    zeros = 0;
    for (int i = 1; i < 60 && i < out_data.size(); i++) if (out_data[i] === 8'h00) zeros++;
    checks++;
    if (out_data[0] !== 8'hAA || zeros != 59) begin
      errors++; $display("FAIL pad_body: got first=%h zeros=%0d, required first=aa zeros=59", out_data[0], zeros);
    end
    checks++;
    if (~crc_raw(out_data) !== 32'h2144DF1C) begin
      errors++; $display("FAIL pad_residue: got %h, required 2144df1c", ~crc_raw(out_data));
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL pad_stream: beat %0d got %h/%b/%b, required %h/%b/%b",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d]);
    end
  endtask

  task automatic test_boundary();
    int lens[3]  = '{59, 60, 61};
    int beats[3] = '{64, 64, 65};
    bq_t f;
    int d;
    mon_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clear_queues();
      f = rand_frame(lens[k]);
      add_expected(1'b1, f, 1'b0);
      drive_frame(1'b1, f, 1'b0, 0);
      wait_beats(beats[k]);
      checks++;
      if (out_data.size() != beats[k]) begin
        errors++; $display("FAIL boundary_beats len=%0d: got %0d, required %0d", lens[k], out_data.size(), beats[k]);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++;
        $display("FAIL boundary_stream len=%0d: beat %0d got %h/%b/%b, required %h/%b/%b", lens[k],
                 d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d]);
      end
    end
  endtask

  task automatic test_tuser();
    bq_t f = rand_frame(10);
    int d, ones;
    mon_sel = 1'b1;
    clear_queues();
    add_expected(1'b1, f, 1'b1);
    drive_frame(1'b1, f, 1'b1, 0);
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++; $display("FAIL busy_during_pad: got %b, required 1", busy[1]);
    end
    wait_beats(64);
    ones = 0;
    foreach (out_user[i]) if (out_user[i]) ones++;
    checks++;
    if (ones != 1 || out_user[63] !== 1'b1) begin
      errors++; $display("FAIL tuser_final: got %0d flagged beats last=%b, required 1 flagged on beat 63", ones, out_user[63]);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL tuser_stream: beat %0d got %h/%b/%b, required %h/%b/%b",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d]);
    end
    checks++;
    if (busy[1] !== 1'b0) begin
      errors++; $display("FAIL busy_after_frame: got %b, required 0", busy[1]);
    end
  endtask

  task automatic test_back_to_back();
    bq_t f;
    bit u;
    int d, total, span;
    int glens[2] = '{5, 70};
    mon_sel = 1'b1;
    clear_queues();
    rand_ready = 1'b1;
    total = 0;
    for (int k = 0; k < 3; k++) begin
      f = rand_frame(int'($urandom_range(1, 100)));
      u = 1'($urandom_range(0, 1));
      add_expected(1'b1, f, u);
      drive_frame(1'b1, f, u, 30);
    end
    wait_beats(exp_data.size());
    rand_ready = 1'b0;
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL stall_stream: beat %0d got %h/%b/%b, required %h/%b/%b (%0d of %0d beats)",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d],
               out_data.size(), exp_data.size());
    end
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      f = rand_frame(glens[k]);
      add_expected(1'b1, f, 1'b0);
      total += (glens[k] < 60 ? 60 : glens[k]) + 4;
    end
    drive_frame(1'b1, exp_data[0:4], 1'b0, 0);
    drive_frame(1'b1, exp_data[64:133], 1'b0, 0);
    wait_beats(total);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_stream: beat %0d got %h/%b/%b, required %h/%b/%b",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d]);
    end
    span = (out_cyc.size() > 0) ? out_cyc[out_cyc.size()-1] - out_cyc[0] + 1 : 0;
    checks++;
    if (span != total) begin
      errors++; $display("FAIL b2b_gapless: got %0d cycles for the beats, required %0d", span, total);
    end
  endtask

  task automatic test_reset_mid_pad();
    bq_t f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    bq_t one = '{8'h55};
    int d;
    mon_sel = 1'b1;
    clear_queues();
    drive_frame(1'b1, one, 1'b0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (busy[1] !== 1'b1 || m_tvalid[1] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pad: got busy=%b tvalid=%b, required 1 1", busy[1], m_tvalid[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_tvalid[1], m_tlast[1], m_tuser[1], busy[1], s_tready[1]} !== 5'b0 || m_tdata1 !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got v=%b l=%b u=%b busy=%b rdy=%b d=%h, required all 0",
               m_tvalid[1], m_tlast[1], m_tuser[1], busy[1], s_tready[1], m_tdata1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_queues();
    add_expected(1'b1, f, 1'b0);
    drive_frame(1'b1, f, 1'b0, 0);
    wait_beats(64);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL post_reset_stream: beat %0d got %h/%b/%b, required %h/%b/%b (%0d beats)",
               d, out_data[d], out_last[d], out_user[d], exp_data[d], exp_last[d], exp_user[d], out_data.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tvalid = 2'b00;
    s_tdata = 8'h00;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    m_tready = 1'b1;
    test_reset();
    test_known_vector();
    test_min_pad();
    test_boundary();
    test_tuser();
    test_back_to_back();
    test_reset_mid_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
